// File: rtl/sensor_sched_pkg.sv
// Shared definitions for the ultrasonic sensor scheduler: FSM state codes,
// default timing parameters and counter sizing helpers.
package sensor_sched_pkg;

    // Default timing at 50 MHz
    localparam int TIMEOUT_CYCLES_DEF = 1_500_000;  // 30 ms echo window
    localparam int MEDIR_CYCLES_DEF   = 5;          // hc_medir pulse width
    localparam int GAP_CYCLES_DEF     = 3_000_000;  // 60 ms rest between shots
    localparam int RECUPERA_CYCLES    = 2;          // hc_reset pulse width

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ARBITRA   = 4'd1,
        MEDE      = 4'd2,
        ESPERA    = 4'd3,
        RECUPERA  = 4'd4,
        ENTREGA   = 4'd5,
        INTERVALO = 4'd6
    } estado_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold maxv without wrapping
    function automatic int cnt_width(input int maxv);
        return (maxv < 2) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/contador_ciclos.sv
// Loadable down-counter. tc_o flags the last cycle of a loaded interval:
// loading N gives N cycles, tc_o high in the N-th. Saturates at zero.
module contador_ciclos #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] valor_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over counting; never decrement past zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = valor_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/sensor_scheduler.sv
// Round-robin scheduler sharing one HC-SR04 interface between two requesters.
// Optional feature: define SENSOR_SCHED_RETRY_EN to retry once after the
// first echo timeout of a grant before reporting timeout.
module sensor_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int MEDIR_CYCLES   = MEDIR_CYCLES_DEF,
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        timeout,
    output logic [11:0] medida,
    output logic        hc_medir,
    input  logic        hc_pronto,
    input  logic [11:0] hc_medida,
    output logic        hc_reset,
    output logic [3:0]  db_estado
);

    localparam int CW = cnt_width(max3(TIMEOUT_CYCLES, MEDIR_CYCLES, GAP_CYCLES));

    estado_t     estado_q, estado_d;
    logic [1:0]  grant_q, grant_d;
    logic        prio_q, prio_d;      // requester holding priority on a tie
    logic        timeout_q, timeout_d;
    logic [11:0] medida_q, medida_d;
    logic [1:0]  escolha;
    logic        cnt_load;
    logic [CW-1:0] cnt_valor;
    logic        cnt_tc;
`ifdef SENSOR_SCHED_RETRY_EN
    logic        retry_q, retry_d;    // the one retry of this grant is spent
`endif

    contador_ciclos #(.W(CW)) u_contador (
        .clock   (clock),
        .reset   (reset),
        .load_i  (cnt_load),
        .valor_i (cnt_valor),
        .tc_o    (cnt_tc)
    );

    // Round-robin pick: the priority requester first, otherwise the other one
    always_comb begin
        escolha = 2'b00;
        if (req[prio_q]) begin
            escolha[prio_q] = 1'b1;
        end else if (req[~prio_q]) begin
            escolha[~prio_q] = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= IDLE;
            grant_q   <= 2'b00;
            prio_q    <= 1'b0;
            timeout_q <= 1'b0;
            medida_q  <= '0;
`ifdef SENSOR_SCHED_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            grant_q   <= grant_d;
            prio_q    <= prio_d;
            timeout_q <= timeout_d;
            medida_q  <= medida_d;
`ifdef SENSOR_SCHED_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    // Next state, counter loads and result capture
    always_comb begin
        estado_d  = estado_q;
        grant_d   = grant_q;
        prio_d    = prio_q;
        timeout_d = timeout_q;
        medida_d  = medida_q;
        cnt_load  = 1'b0;
        cnt_valor = '0;
`ifdef SENSOR_SCHED_RETRY_EN
        retry_d   = retry_q;
`endif
        case (estado_q)
            IDLE: begin
                if (req != 2'b00) estado_d = ARBITRA;
            end
            ARBITRA: begin
                // A request that vanished before this sample is dropped
                if (escolha != 2'b00) begin
                    grant_d   = escolha;
                    prio_d    = escolha[0];   // the other requester leads next time
                    cnt_load  = 1'b1;
                    cnt_valor = CW'(MEDIR_CYCLES);
                    estado_d  = MEDE;
`ifdef SENSOR_SCHED_RETRY_EN
                    retry_d   = 1'b0;
`endif
                end else begin
                    estado_d = IDLE;
                end
            end
            MEDE: begin
                if (cnt_tc) begin
                    cnt_load  = 1'b1;
                    cnt_valor = CW'(TIMEOUT_CYCLES);
                    estado_d  = ESPERA;
                end
            end
            ESPERA: begin
                // An echo on the limit cycle still counts as a result
                if (hc_pronto) begin
                    medida_d  = hc_medida;
                    timeout_d = 1'b0;
                    estado_d  = ENTREGA;
                end else if (cnt_tc) begin
                    cnt_load  = 1'b1;
                    cnt_valor = CW'(RECUPERA_CYCLES);
                    estado_d  = RECUPERA;
                end
            end
            RECUPERA: begin
                if (cnt_tc) begin
`ifdef SENSOR_SCHED_RETRY_EN
                    if (!retry_q) begin
                        retry_d   = 1'b1;
                        cnt_load  = 1'b1;
                        cnt_valor = CW'(MEDIR_CYCLES);
                        estado_d  = MEDE;
                    end else begin
                        medida_d  = '0;
                        timeout_d = 1'b1;
                        estado_d  = ENTREGA;
                    end
`else
                    medida_d  = '0;
                    timeout_d = 1'b1;
                    estado_d  = ENTREGA;
`endif
                end
            end
            ENTREGA: begin
                grant_d   = 2'b00;
                cnt_load  = 1'b1;
                cnt_valor = CW'(GAP_CYCLES);
                estado_d  = INTERVALO;
            end
            INTERVALO: begin
                if (cnt_tc) estado_d = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        grant     = grant_q;
        done      = (estado_q == ENTREGA) ? grant_q : 2'b00;
        hc_medir  = (estado_q == MEDE);
        hc_reset  = (estado_q == RECUPERA);
        timeout   = timeout_q;
        medida    = medida_q;
        db_estado = estado_q;
    end

endmodule
